// File: rtl/sdram_pkg.sv
// sdram_pkg: command encoding, mode field positions and state enums shared by SDRAM controller and responder
package sdram_pkg;
    localparam logic [2:0] CMD_LOAD_MODE = 3'b000;
    localparam logic [2:0] CMD_REFRESH   = 3'b001;
    localparam logic [2:0] CMD_PRECHARGE = 3'b010;
    localparam logic [2:0] CMD_ACTIVE    = 3'b011;
    localparam logic [2:0] CMD_WRITE     = 3'b100;
    localparam logic [2:0] CMD_READ      = 3'b101;
    localparam logic [2:0] CMD_BST       = 3'b110;
    localparam logic [2:0] CMD_NOP       = 3'b111;
    localparam int CL_MSB = 6;
    localparam int CL_LSB = 4;
    localparam int BL_MSB = 2;
    localparam int BL_LSB = 0;
    typedef enum logic {B_IDLE, B_OPEN} bank_state_e;
    typedef enum logic {G_UNINIT, G_READY} gstate_e;
    function automatic logic [23:0] make_idx(input logic [1:0] bank, input logic [12:0] row, input logic [8:0] col);
        return {bank, row, col};
    endfunction
endpackage

// File: rtl/sdram_responder_if.sv
// sdram_responder_if: SDRAM pin bundle between controller (master) and device (slave)
interface sdram_responder_if;
    logic        clock_enable;
    logic        cs_n;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [12:0] addr;
    logic [1:0]  bank_addr;
    logic        data_oe;
    logic [15:0] data_out;
    logic        data_mask_low;
    logic        data_mask_high;
    logic [15:0] data_in;
    logic        data_in_valid;
    modport master (
        output clock_enable, cs_n, ras_n, cas_n, we_n, addr, bank_addr,
               data_oe, data_out, data_mask_low, data_mask_high,
        input  data_in, data_in_valid
    );
    modport slave (
        input  clock_enable, cs_n, ras_n, cas_n, we_n, addr, bank_addr,
               data_oe, data_out, data_mask_low, data_mask_high,
        output data_in, data_in_valid
    );
endinterface

// File: rtl/sdram_responder_mem.sv
// sdram_responder_mem: byte-writable RAM, synchronous write, combinational read
module sdram_responder_mem #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic [1:0]    be_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [15:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [15:0]   rdata_o
);
    logic [15:0] mem_q [2**AW];

    // byte-enabled write; a read at the same address this cycle still sees old data
    always_ff @(posedge clk) begin
        if (be_i[0]) mem_q[waddr_i][7:0] <= wdata_i[7:0];
        if (be_i[1]) mem_q[waddr_i][15:8] <= wdata_i[15:8];
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sdram_responder.sv
// sdram_responder: SDR SDRAM device model decoding controller commands into a small RAM with error flagging
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int MEM_AW = 10,
    parameter int NBANK  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    sdram_responder_if.slave bus,
    output logic             proto_err_o,
    output logic [15:0]      refresh_cnt_o
);
    gstate_e           gstate_q;
    bank_state_e       bank_q [NBANK];
    logic [12:0]       row_q [NBANK];
    logic              cl3_q, bl2_q;
    logic              pend_q, pend_wr_q, pend_ap_q;
    logic [1:0]        pend_bank_q;
    logic [MEM_AW-1:0] pend_idx_q;
    logic [2:0]        pv_q;
    logic [MEM_AW-1:0] pidx_q [3];
    logic [15:0]       data_in_q, refresh_q;
    logic              valid_q, err_q;
    logic              cke, any_open, bank_open, is_rw, rw_ok, rw_wr, b1_go, cl_ok, bl_ok;
    logic              err, push_v, wr_en, tap_v;
    logic [2:0]        cmd;
    logic [MEM_AW-1:0] rw_idx, beat_idx, tap_idx;
    logic [1:0]        wr_be;
    logic [15:0]       rdata;

    // command decode, burst continuation, error detection and memory/pipeline steering
    always_comb begin
        cke = bus.clock_enable;
        cmd = (cke && !bus.cs_n) ? {bus.ras_n, bus.cas_n, bus.we_n} : CMD_NOP;
        any_open = 1'b0;
        for (int i = 0; i < NBANK; i++) any_open = any_open | (bank_q[i] == B_OPEN);
        bank_open = bank_q[bus.bank_addr] == B_OPEN;
        is_rw = (cmd == CMD_READ) || (cmd == CMD_WRITE);
        rw_ok = is_rw && gstate_q == G_READY && bank_open;
        rw_wr = rw_ok && cmd == CMD_WRITE;
        b1_go = cke && pend_q && !is_rw && cmd != CMD_BST;
        cl_ok = bus.addr[CL_MSB:CL_LSB] inside {3'd2, 3'd3};
        bl_ok = bus.addr[BL_MSB:BL_LSB] inside {3'd0, 3'd1};
        rw_idx = MEM_AW'(make_idx(bus.bank_addr, row_q[bus.bank_addr], bus.addr[8:0]));
        beat_idx = rw_ok ? rw_idx : pend_idx_q;
        wr_en = (rw_wr || (b1_go && pend_wr_q)) && bus.data_oe;
        wr_be = wr_en ? ~{bus.data_mask_high, bus.data_mask_low} : 2'b00;
        push_v = (rw_ok && cmd == CMD_READ) || (b1_go && !pend_wr_q);
        tap_v = cl3_q ? pv_q[2] : pv_q[1];
        tap_idx = cl3_q ? pidx_q[2] : pidx_q[1];
        err = ((is_rw || cmd == CMD_ACTIVE) && gstate_q == G_UNINIT)
            || (is_rw && gstate_q == G_READY && !bank_open)
            || (cmd == CMD_ACTIVE && gstate_q == G_READY && bank_open)
            || (cmd == CMD_REFRESH && any_open)
            || (cmd == CMD_LOAD_MODE && (any_open || !cl_ok || !bl_ok))
            || ((rw_wr || (b1_go && pend_wr_q)) && !bus.data_oe);
    end

    sdram_responder_mem #(.AW(MEM_AW)) u_mem (
        .clk     (clk),
        .be_i    (wr_be),
        .waddr_i (beat_idx),
        .wdata_i (bus.data_out),
        .raddr_i (tap_idx),
        .rdata_o (rdata)
    );

    // device state; CKE low freezes everything including the CAS pipeline and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gstate_q    <= G_UNINIT;
            cl3_q       <= 1'b0;
            bl2_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_wr_q   <= 1'b0;
            pend_ap_q   <= 1'b0;
            pend_bank_q <= 2'd0;
            pend_idx_q  <= '0;
            pv_q        <= 3'b000;
            data_in_q   <= 16'h0000;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            refresh_q   <= 16'h0000;
            for (int i = 0; i < 3; i++) pidx_q[i] <= '0;
            for (int i = 0; i < NBANK; i++) begin
                bank_q[i] <= B_IDLE;
                row_q[i]  <= 13'h0000;
            end
        end else if (cke) begin
            pv_q      <= {pv_q[1:0], push_v};
            pidx_q[0] <= beat_idx;
            pidx_q[1] <= pidx_q[0];
            pidx_q[2] <= pidx_q[1];
            valid_q   <= tap_v;
            data_in_q <= tap_v ? rdata : 16'h0000;
            err_q     <= err_q | err;
            if (cmd == CMD_REFRESH) refresh_q <= refresh_q + 16'd1;
            if (cmd == CMD_LOAD_MODE) begin
                gstate_q <= G_READY;
                if (cl_ok) cl3_q <= bus.addr[CL_LSB];
                if (bl_ok) bl2_q <= bus.addr[BL_LSB];
            end
            pend_q      <= rw_ok && bl2_q;
            pend_wr_q   <= cmd == CMD_WRITE;
            pend_ap_q   <= bus.addr[10];
            pend_bank_q <= bus.bank_addr;
            pend_idx_q  <= rw_idx ^ MEM_AW'(1);
            if (pend_q && pend_ap_q) bank_q[pend_bank_q] <= B_IDLE;
            if (rw_ok && bus.addr[10] && !bl2_q) bank_q[bus.bank_addr] <= B_IDLE;
            if (cmd == CMD_ACTIVE && gstate_q == G_READY) begin
                bank_q[bus.bank_addr] <= B_OPEN;
                row_q[bus.bank_addr]  <= bus.addr;
            end
            if (cmd == CMD_PRECHARGE)
                for (int i = 0; i < NBANK; i++)
                    if (bus.addr[10] || 2'(i) == bus.bank_addr) bank_q[i] <= B_IDLE;
        end
    end

    assign bus.data_in       = data_in_q;
    assign bus.data_in_valid = valid_q;
    assign proto_err_o       = err_q;
    assign refresh_cnt_o     = refresh_q;
endmodule
